product_selection: RTL and testbench



---
 rtl/product_selection_pkg.sv | 19 +
 rtl/product_selection_price_lut.sv | 35 +++
 rtl/product_selection.sv | 56 +++++
 tb/tb_product_selection.sv | 115 +++++++++++
 4 files changed

// File: rtl/product_selection_pkg.sv
// product_selection_pkg
//   Shared types and default parameters for the vending-machine product selector.
//   product_code_t : 2-bit keypad product code (none / A / B / C)
//   PRICE_*_DEF    : default prices and output width
package product_selection_pkg;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_A    = 2'b01,
        SEL_B    = 2'b10,
        SEL_C    = 2'b11
    } product_code_t;

    localparam int PRICE_W_DEF = 5;
    localparam int PRICE_A_DEF = 15;
    localparam int PRICE_B_DEF = 20;
    localparam int PRICE_C_DEF = 25;

endpackage

// File: rtl/product_selection_price_lut.sv
// price_lut
//   Purely combinational product code -> price decode.
//   Ports:
//     code   in   2        product code (00 none, 01 A, 10 B, 11 C)
//     price  out  PRICE_W  decoded price; none or unknown codes decode to 0
//   Elaboration stops if any price does not fit in PRICE_W bits, so a
//   misconfigured price can never be silently truncated.
module price_lut
    import product_selection_pkg::*;
#(
    parameter int PRICE_W = PRICE_W_DEF,
    parameter int PRICE_A = PRICE_A_DEF,
    parameter int PRICE_B = PRICE_B_DEF,
    parameter int PRICE_C = PRICE_C_DEF
) (
    input  logic [1:0]         code,
    output logic [PRICE_W-1:0] price
);

    if (PRICE_A >= (1 << PRICE_W) || PRICE_B >= (1 << PRICE_W) ||
        PRICE_C >= (1 << PRICE_W) || PRICE_A < 0 || PRICE_B < 0 || PRICE_C < 0) begin : g_price_range_chk
        $error("price_lut: a PRICE_* value does not fit in PRICE_W bits");
    end

    always_comb begin
        price = '0;
        case (code)
            SEL_A:   price = PRICE_W'(PRICE_A);
            SEL_B:   price = PRICE_W'(PRICE_B);
            SEL_C:   price = PRICE_W'(PRICE_C);
            default: price = '0;  // SEL_NONE and X/Z codes
        endcase
    end

endmodule

// File: rtl/product_selection.sv
// product_selection
//   Maps the keypad product code to its price and registers it for the
//   payment/compare datapath. One registered decode stage, 1-cycle latency,
//   no combinational path from product_sel to selected_price.
//   Ports:
//     clk             in   1        system clock, rising edge
//     reset           in   1        synchronous, active-high; clears the price
//     product_sel     in   2        product code (00 none, 01 A, 10 B, 11 C)
//     selected_price  out  PRICE_W  registered price of the current selection
//   Build option PRODUCT_SEL_HOLD_EN:
//     defined   - code 00 keeps the last loaded price until a new selection or reset
//     undefined - code 00 loads 0 on the next edge
module product_selection
    import product_selection_pkg::*;
#(
    parameter int PRICE_W = PRICE_W_DEF,
    parameter int PRICE_A = PRICE_A_DEF,
    parameter int PRICE_B = PRICE_B_DEF,
    parameter int PRICE_C = PRICE_C_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         product_sel,
    output logic [PRICE_W-1:0] selected_price
);

    logic [PRICE_W-1:0] lut_price;

    price_lut #(
        .PRICE_W (PRICE_W),
        .PRICE_A (PRICE_A),
        .PRICE_B (PRICE_B),
        .PRICE_C (PRICE_C)
    ) u_price_lut (
        .code  (product_sel),
        .price (lut_price)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            selected_price <= '0;
        end else begin
`ifdef PRODUCT_SEL_HOLD_EN
            // Only an explicit "none" holds; an unknown code falls through to
            // the LUT, which decodes it to 0.
            if (product_sel == SEL_NONE)
                selected_price <= selected_price;
            else
                selected_price <= lut_price;
`else
            selected_price <= lut_price;
`endif
        end
    end

endmodule

// File: tb/tb_product_selection.sv
module tb_product_selection;

`ifdef PRODUCT_SEL_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] product_sel;
    logic [4:0] selected_price;
    logic [4:0] selected_price_max;

    int n_cmp = 0;
    int n_err = 0;

    // Reference price tables: default build and the PRICE_A=31 override.
    int tab_def[4] = '{0, 15, 20, 25};
    int tab_max[4] = '{0, 31, 20, 25};
    int model_def;
    int model_max;
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    product_selection u_dut (
        .clk            (clk),
        .reset          (reset),
        .product_sel    (product_sel),
        .selected_price (selected_price)
    );

    product_selection #(.PRICE_W(5), .PRICE_A(31)) u_dut_max (
        .clk            (clk),
        .reset          (reset),
        .product_sel    (product_sel),
        .selected_price (selected_price_max)
    );

    task automatic check(input string tag, input logic [4:0] got, input int exp);
        n_cmp++;
        assert (got === 5'(exp)) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs mid-cycle, confirm the output has not moved
    // before the edge, then advance the model and compare after the edge.
    task automatic step(input logic [1:0] s, input logic r, input string tag);
        product_sel = s;
        reset       = r;
        #1;
        if (model_valid) begin
            check({tag, "/pre_edge"}, selected_price, model_def);
            check({tag, "/pre_edge_max"}, selected_price_max, model_max);
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_def = 0;
            model_max = 0;
        end else if (!(HOLD && s == 2'b00)) begin
            model_def = tab_def[s];
            model_max = tab_max[s];
        end
        model_valid = 1'b1;
        check(tag, selected_price, model_def);
        check({tag, "_max"}, selected_price_max, model_max);
    endtask

    initial begin
        reset       = 1'b1;
        product_sel = 2'b00;
        @(posedge clk);
        #1;

        // reset held with sel=00, then released
        step(2'b00, 1'b1, "reset0");
        step(2'b00, 1'b1, "reset1");
        step(2'b00, 1'b0, "post_reset");

        // each product, 1-cycle latency
        step(2'b01, 1'b0, "sel_a");
        step(2'b10, 1'b0, "sel_b");
        step(2'b11, 1'b0, "sel_c");

        // none after C: 0 in default build, 25 held with hold enabled
        step(2'b00, 1'b0, "none_after_c");
        step(2'b00, 1'b0, "none_again");

        // mid-operation reset while price is 25
        step(2'b11, 1'b0, "reload_c");
        step(2'b11, 1'b1, "reset_mid");
        step(2'b01, 1'b0, "resume_a");

        // rapid switching 01 -> 11 -> 10, two cycles each
        step(2'b01, 1'b0, "rapid_a0");
        step(2'b01, 1'b0, "rapid_a1");
        step(2'b11, 1'b0, "rapid_c0");
        step(2'b11, 1'b0, "rapid_c1");
        step(2'b10, 1'b0, "rapid_b0");
        step(2'b10, 1'b0, "rapid_b1");

        // randomized codes with occasional resets
        for (int i = 0; i < 200; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
